// File: rtl/mcu_pkg.sv
// Shared constants, load-unit state encoding and load-result helpers.
package mcu_pkg;

   localparam logic [7:0] SPI_CMD_READ = 8'h03;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_DATA,
      ST_DONE,
      ST_FAULT
   } load_state_t;

   // Only the five RV32E load encodings are executable.
   function automatic logic f3_valid(input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
         default:                             ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Number of data bits read from memory for a load type.
   function automatic logic [5:0] load_bits(input logic [2:0] f3);
      logic [5:0] n;
      case (f3)
         F3_LB, F3_LBU: n = 6'd8;
         F3_LH, F3_LHU: n = 6'd16;
         default:       n = 6'd32;
      endcase
      return n;
   endfunction

   // rx holds the received bits with the first-arrived byte highest; the
   // memory is little-endian, so the last-arrived byte is the most significant.
   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] rx);
      logic [31:0] v;
      case (f3)
         F3_LB:   v = {{24{rx[7]}}, rx[7:0]};
         F3_LBU:  v = {24'h0, rx[7:0]};
         F3_LH:   v = {{16{rx[7]}}, rx[7:0], rx[15:8]};
         F3_LHU:  v = {16'h0, rx[7:0], rx[15:8]};
         default: v = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
      endcase
      return v;
   endfunction

endpackage

// File: rtl/spi_load_unit_if.sv
// Request/result handshake plus SPI pins of the load unit.
interface spi_load_unit_if #(parameter int ADDR_WIDTH = 24);

   logic                  start;
   logic [ADDR_WIDTH-1:0] addr;
   logic [2:0]            funct3;
   logic [4:0]            rd;
   logic                  busy;
   logic                  done;
   logic                  fault;
   logic [4:0]            write_register;
   logic [31:0]           write_value;
   logic                  spi_cs_n;
   logic                  spi_sclk;
   logic                  spi_mosi;
   logic                  spi_miso;

   // Control/pipeline side plus the memory side of the SPI bus.
   modport master (
      output start, addr, funct3, rd, spi_miso,
      input  busy, done, fault, write_register, write_value,
      input  spi_cs_n, spi_sclk, spi_mosi
   );

   // The load unit itself.
   modport slave (
      input  start, addr, funct3, rd, spi_miso,
      output busy, done, fault, write_register, write_value,
      output spi_cs_n, spi_sclk, spi_mosi
   );

endinterface

// File: rtl/spi_master_shift.sv
// Mode-0 SPI bit engine at clk/2: loads a word, shifts a given number of bits
// MSB first, captures MISO on the edge that drops SCLK, pulses o_last_bit.
module spi_master_shift #(
   parameter int WORD_W = 64,
   parameter int CNT_W  = 7,
   parameter int RX_W   = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [WORD_W-1:0] i_word,
   input  logic [CNT_W-1:0] i_nbits,
   input  logic             i_miso,
   output logic             o_sclk,
   output logic             o_mosi,
   output logic             o_last_bit,
   output logic [CNT_W-1:0] o_bit_cnt,
   output logic [RX_W-1:0]  o_rx
);

   // MSB of the word goes straight to MOSI at load, so only the rest is kept.
   logic [WORD_W-2:0] r_shreg;
   logic              r_active;
   logic              r_phase;
   logic              r_sclk;
   logic              r_mosi;
   logic              r_last;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_nbits;
   logic [CNT_W-1:0]  w_cnt_nxt;

   assign w_cnt_nxt = r_cnt + CNT_W'(1);

   // Shift data out of the top and MISO into the bottom on each falling SCLK.
   always_ff @(posedge i_clk) begin
      if (i_load)
         r_shreg <= i_word[WORD_W-2:0];
      else if (r_active && r_phase)
         r_shreg <= {r_shreg[WORD_W-3:0], i_miso};
   end

   // Phase toggle, SCLK/MOSI generation and bit counting.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_active <= 1'b0;
         r_phase  <= 1'b0;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b0;
         r_last   <= 1'b0;
         r_cnt    <= '0;
         r_nbits  <= '0;
      end else begin
         r_last <= 1'b0;
         if (i_load) begin
            r_active <= 1'b1;
            r_phase  <= 1'b0;
            r_sclk   <= 1'b0;
            r_mosi   <= i_word[WORD_W-1];
            r_cnt    <= '0;
            r_nbits  <= i_nbits;
         end else if (r_active) begin
            if (!r_phase) begin
               r_sclk  <= 1'b1;
               r_phase <= 1'b1;
            end else begin
               r_sclk  <= 1'b0;
               r_phase <= 1'b0;
               r_cnt   <= w_cnt_nxt;
               if (w_cnt_nxt == r_nbits) begin
                  r_active <= 1'b0;
                  r_last   <= 1'b1;
                  r_mosi   <= 1'b0;
               end else begin
                  r_mosi <= r_shreg[WORD_W-2];
               end
            end
         end
      end
   end

   assign o_sclk     = r_sclk;
   assign o_mosi     = r_mosi;
   assign o_last_bit = r_last;
   assign o_bit_cnt  = r_cnt;
   assign o_rx       = r_shreg[RX_W-1:0];

endmodule

// File: rtl/spi_load_unit.sv
// RV32E load unit: reads bytes from SPI memory, extends them and writes the
// register file for exactly one cycle per completed load.
module spi_load_unit
   import mcu_pkg::*;
#(
   parameter int ADDR_WIDTH = 24
) (
   input logic               clk,
   input logic               rst_n,
   spi_load_unit_if.slave    bus
);

   localparam int CMD_BITS = 8 + ADDR_WIDTH;
   localparam int WORD_W   = CMD_BITS + 32;
   localparam int CNT_W    = $clog2(WORD_W + 1);

   load_state_t      r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_fault;
   logic             r_cs_n;
   logic [4:0]       r_wreg;
   logic [31:0]      r_wval;
   logic [2:0]       r_f3;
   logic [4:0]       r_rd;

   logic             w_accept;
   logic [WORD_W-1:0] w_word;
   logic [CNT_W-1:0] w_nbits;
   logic             w_sclk;
   logic             w_mosi;
   logic             w_last;
   logic [CNT_W-1:0] w_cnt;
   logic [31:0]      w_rx;

   // The whole command, address and data phase is one continuous transfer.
   assign w_accept = (r_state == ST_IDLE) && bus.start && f3_valid(bus.funct3);
   assign w_word   = {SPI_CMD_READ, bus.addr, 32'h0};
   assign w_nbits  = CNT_W'(CMD_BITS) + CNT_W'(load_bits(bus.funct3));

   spi_master_shift #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W),
      .RX_W   (32)
   ) u_shift (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_load     (w_accept),
      .i_word     (w_word),
      .i_nbits    (w_nbits),
      .i_miso     (bus.spi_miso),
      .o_sclk     (w_sclk),
      .o_mosi     (w_mosi),
      .o_last_bit (w_last),
      .o_bit_cnt  (w_cnt),
      .o_rx       (w_rx)
   );

   // Load sequencing with registered handshake and register-file outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_fault <= 1'b0;
         r_cs_n  <= 1'b1;
         r_wreg  <= '0;
         r_wval  <= '0;
         r_f3    <= F3_LB;
         r_rd    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_f3 <= bus.funct3;
                  r_rd <= bus.rd;
                  if (f3_valid(bus.funct3)) begin
                     r_state <= ST_CMD;
                     r_busy  <= 1'b1;
                     r_cs_n  <= 1'b0;
                  end else begin
                     r_state <= ST_FAULT;
                     r_fault <= 1'b1;
                  end
               end
            end
            ST_CMD: begin
               if (w_cnt == CNT_W'(CMD_BITS))
                  r_state <= ST_DATA;
            end
            ST_DATA: begin
               if (w_last) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_cs_n  <= 1'b1;
                  r_wreg  <= r_rd;
                  // x0 is never written, so its value bus stays quiet too.
                  r_wval  <= (r_rd != 5'd0) ? load_extend(r_f3, w_rx) : 32'h0;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_wreg  <= '0;
               r_wval  <= '0;
            end
            ST_FAULT: begin
               r_state <= ST_IDLE;
               r_fault <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy           = r_busy;
   assign bus.done           = r_done;
   assign bus.fault          = r_fault;
   assign bus.write_register = r_wreg;
   assign bus.write_value    = r_wval;
   assign bus.spi_cs_n       = r_cs_n;
   assign bus.spi_sclk       = w_sclk;
   assign bus.spi_mosi       = w_mosi;

endmodule

// File: doc/spi_load_unit.md
# spi_load_unit

Executes RV32E load instructions (LB/LH/LW/LBU/LHU) against external SPI memory and writes the extended result into the register file. It sits between the execute/decode control and the register file. It owns the SPI read transaction, byte assembly, and sign/zero extension. It drives the register file's `write_register`/`write_value` pair for exactly one cycle per completed load.

## Interface

Parameters:
- `ADDR_WIDTH`, default 24: SPI memory byte-address width, sent MSB first after the command byte.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: load request; sampled only in IDLE.
- `addr`, in, ADDR_WIDTH: byte address of the load; latched on accepted `start`.
- `funct3`, in, 3: load type; latched on accepted `start`.
- `rd`, in, 5: destination register; latched on accepted `start`.
- `busy`, out, 1: high from the cycle after accept until the DONE cycle, inclusive.
- `done`, out, 1: one-cycle pulse when the result is written.
- `fault`, out, 1: one-cycle pulse for an unsupported `funct3`.
- `write_register`, out, 5: register-file write index; 0 whenever no write is occurring.
- `write_value`, out, 32: register-file write data; 0 when `write_register` is 0.
- `spi_cs_n`, out, 1: chip select, active-low.
- `spi_sclk`, out, 1: SPI clock, mode 0, clk/2.
- `spi_mosi`, out, 1: master data out.
- `spi_miso`, in, 1: slave data in.

## Operation

- **States:**
  - IDLE → CMD on `start` with valid `funct3`.
  - IDLE → FAULT on `start` with `funct3` ∈ {011, 110, 111}.
  - CMD → DATA after 8 + ADDR_WIDTH bits.
  - DATA → DONE after 8·N bits, where N = 1 (LB/LBU), 2 (LH/LHU), 4 (LW).
  - DONE → IDLE.
  - FAULT → IDLE.
- **CMD:** shift out 8'h03 then `addr`, both MSB first. MISO is ignored.
- **DATA:** MOSI is held 0.
  - Bytes arrive lowest-address first and are little-endian: byte k fills result bits [8k+7:8k].
  - Bits within each byte arrive MSB first.
- **Extension:**
  - LB sign-extends bit 7; LBU zero-extends.
  - LH sign-extends bit 15; LHU zero-extends.
  - LW takes all 32 bits unmodified.
- **DONE:**
  - `write_register` = latched `rd`, `write_value` = extended result, `done` = 1, for one cycle.
  - `rd` = 0 still performs the transfer and pulses `done`; `write_register` stays 0.
- **FAULT:**
  - `fault` = 1 for one cycle; no SPI activity.
  - `write_register` stays 0 and `done` stays 0.
- **Ignored `start`:** `start` is ignored in every state other than IDLE; there is no queueing.
- **Outside DONE:** `write_register` and `write_value` are held at 0. The register file writes on every cycle with a nonzero index, so this is mandatory.

## Timing

- **Reset values:** `busy`=0, `done`=0, `fault`=0, `write_register`=0, `write_value`=0, `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0.
- **Reset mid-transfer:** asserting `rst_n` low mid-transfer forces all of the above immediately (asynchronously). The state returns to IDLE and no write occurs.
- **Bit timing:** each SPI bit takes 2 clk cycles.
  - Phase 0: `spi_sclk`=0 and `spi_mosi` is updated.
  - Phase 1: `spi_sclk`=1.
  - MISO is sampled on the clk edge that returns `spi_sclk` to 0.
- **Chip select:** `spi_cs_n` falls the cycle after accept, stays low through the last DATA bit, and rises in DONE.
- **Latency:** with `start` sampled at edge 0, `done` is high 2 + 2·(8+ADDR_WIDTH) + 16·N cycles later.
  - Default `ADDR_WIDTH`: LB = 82, LH = 98, LW = 130.
- **FAULT latency:** `fault` is high on the cycle after accept.
- **Back-to-back:** a new `start` may be accepted on the cycle after DONE. `spi_cs_n` is then high for at least one cycle between transactions.
- **Counters:**
  - The bit counter covers 0..(8+ADDR_WIDTH+32)−1 with no wrap-around.
  - The phase toggle resets to 0 on accept.

## Structure

- **Shared package `mcu_pkg`:**
  - `SPI_CMD_READ` = 8'h03.
  - `funct3` constants: `F3_LB`=000, `F3_LH`=001, `F3_LW`=010, `F3_LBU`=100, `F3_LHU`=101.
  - Load-unit state encoding: IDLE, CMD, DATA, DONE, FAULT.
- **Sub-module `spi_master_shift`:** generic clk/2 mode-0 bit engine.
  - Load a word, shift a given bit count, capture MISO, assert `last_bit`.
  - The FSM, byte assembly and extension remain in `spi_load_unit`.

## Test plan

- **LW:** `addr`=0x000100, `rd`=3, memory bytes 78 56 34 12 → MOSI carries 0x03 0x00 0x01 0x00. `done` at cycle 130 with `write_register`=3 and `write_value`=0x12345678; zero otherwise.
- **LB vs LBU:** LB `rd`=2 on byte 0x80 → 0xFFFFFF80 at cycle 82. LBU on the same byte → 0x00000080. LH on bytes 01 80 → 0xFFFF8001. LHU on bytes 01 80 → 0x00008001.
- **`start` while busy:** pulse `start` at cycles 5 and 60 during an LW → exactly one transaction and one `done` pulse. A new `start` on the cycle after DONE is accepted.
- **Reset mid-DATA:** assert `rst_n`=0 at cycle 100 of an LW → `spi_cs_n`=1 and `spi_sclk`=0 without waiting for a clk edge. No `done` pulse; `write_register` stays 0.
- **Invalid `funct3`:** `funct3`=011 → `fault` high for one cycle at cycle 1. `spi_cs_n` never falls and `busy`/`done` stay 0.
- **`rd`=0:** LW with `rd`=0 → full SPI transaction and `done` at 130, with `write_register`=0 and `write_value`=0 throughout.
